// File: rtl/uart_tx.sv
`timescale 1ns/1ps
// uart_tx: parallel-to-serial UART transmitter, LSB first, valid/ready input.
// Frame: start bit, DLEN data bits, optional parity bit, 1 or 2 stop bits.
// Every output is a flop, so o_tx is glitch-free and no input reaches an output
// combinationally.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  S_IDLE   | line at mark, o_ready=1, waiting for i_valid
//  S_START  | start bit (0) for CLKS_PER_BIT cycles
//  S_DATA   | data bits, LSB first, bit_q counts 0..DLEN-1
//  S_PARITY | parity bit of the captured word (only when PARITY_EN)
//  S_STOP   | stop bit(s) at mark, stop_q counts 0..STOP_BITS-1
module uart_tx #(
  parameter int DLEN         = 8,
  parameter int CLKS_PER_BIT = 868,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [DLEN-1:0] i_data,
  output logic            o_tx,
  output logic            o_busy
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = (DLEN > 1) ? $clog2(DLEN) : 1;

  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] BIT_LAST  = IW'(DLEN - 1);
  localparam logic          STOP_LAST = (STOP_BITS == 2);
  localparam logic          ODD_SEL   = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e          state_q;
  logic [BW-1:0]   baud_q;
  logic [IW-1:0]   bit_q;
  logic [DLEN-1:0] shift_q;
  logic            parity_q;
  logic            stop_q;
  logic            tx_q;
  logic            ready_q;
  logic            busy_q;

  logic            baud_tc_d;
  logic            parity_d;

  // Terminal count of the baud timer and parity of the word being accepted.
  always_comb begin
    baud_tc_d = (baud_q == BAUD_LAST);
    parity_d  = (^i_data) ^ ODD_SEL;
  end

  // Frame sequencer: state, baud timer, bit/stop counters and registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      parity_q <= 1'b0;
      stop_q   <= 1'b0;
      tx_q     <= 1'b1;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      // Baud timer free-runs while a frame is in flight; IDLE holds it at zero
      // so START always begins with a full bit period.
      baud_q <= baud_tc_d ? '0 : baud_q + 1'b1;

      case (state_q)
        S_IDLE: begin
          baud_q  <= '0;
          bit_q   <= '0;
          stop_q  <= 1'b0;
          tx_q    <= 1'b1;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          // ready_q gates the handshake so the reset-release edge never accepts.
          if (ready_q && i_valid) begin
            state_q  <= S_START;
            shift_q  <= i_data;
            parity_q <= parity_d;
            tx_q     <= 1'b0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b1;
          end
        end

        S_START: begin
          if (baud_tc_d) begin
            state_q <= S_DATA;
            bit_q   <= '0;
            tx_q    <= shift_q[0];
            shift_q <= {1'b0, shift_q[DLEN-1:1]};
          end
        end

        S_DATA: begin
          if (baud_tc_d) begin
            if (bit_q == BIT_LAST) begin
              stop_q <= 1'b0;
              if (PARITY_EN != 0) begin
                state_q <= S_PARITY;
                tx_q    <= parity_q;
              end else begin
                state_q <= S_STOP;
                tx_q    <= 1'b1;
              end
            end else begin
              bit_q   <= bit_q + 1'b1;
              tx_q    <= shift_q[0];
              shift_q <= {1'b0, shift_q[DLEN-1:1]};
            end
          end
        end

        S_PARITY: begin
          if (baud_tc_d) begin
            state_q <= S_STOP;
            stop_q  <= 1'b0;
            tx_q    <= 1'b1;
          end
        end

        S_STOP: begin
          tx_q <= 1'b1;
          if (baud_tc_d) begin
            if (stop_q == STOP_LAST) begin
              state_q <= S_IDLE;
              ready_q <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              stop_q <= 1'b1;
            end
          end
        end

        default: begin
          state_q <= S_IDLE;
          tx_q    <= 1'b1;
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign o_tx    = tx_q;
  assign o_ready = ready_q;
  assign o_busy  = busy_q;

endmodule
